sha2_schedule_engine: RTL and testbench

Parametrised SHA-2 message-schedule generator. Accepts one 16-word message block and streams the expanded words W[0]..W[ROUNDS-1], one word per handshake, to the compression round logic. It supersedes the fixed SHA-256 scheduling unit. One instance serves SHA-224/256 (32-bit, 64 rounds) or SHA-384/512 (64-bit, 80 rounds), and a stalling consumer is supported.

---
 rtl/sha2_schedule_engine_if.sv | 51 +++++
 rtl/sha2_schedule_engine.sv | 166 ++++++++++++++++
 tb/tb_sha2_schedule_engine.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha2_schedule_engine_if.sv
// -----------------------------------------------------------------------------
// sha2_schedule_engine_if
// Groups the block-load and word-stream signals of the SHA-2 message-schedule
// engine.
//   start     : load block_in and begin (master -> engine)
//   block_in  : 16-word message block, word 0 in the MSB slice
//   busy      : engine is streaming a block
//   w_valid   : w_out / w_index hold a valid schedule word
//   w_ready   : consumer accepts the current word (master -> engine)
//   w_out     : current schedule word W[t]
//   w_index   : current round index t
//   done      : one-cycle pulse after the final word is transferred
//   abort     : only when SHA2_SCHED_ABORT_EN is defined; drops the block
// Modports: master (block source / word consumer), slave (the engine).
// -----------------------------------------------------------------------------
interface sha2_schedule_engine_if #(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 6
);
    logic                  start;
    logic [16*WORD_W-1:0]  block_in;
    logic                  busy;
    logic                  w_valid;
    logic                  w_ready;
    logic [WORD_W-1:0]     w_out;
    logic [IDX_W-1:0]      w_index;
    logic                  done;
`ifdef SHA2_SCHED_ABORT_EN
    logic                  abort;

    modport master (
        output start, block_in, w_ready, abort,
        input  busy, w_valid, w_out, w_index, done
    );

    modport slave (
        input  start, block_in, w_ready, abort,
        output busy, w_valid, w_out, w_index, done
    );
`else
    modport master (
        output start, block_in, w_ready,
        input  busy, w_valid, w_out, w_index, done
    );

    modport slave (
        input  start, block_in, w_ready,
        output busy, w_valid, w_out, w_index, done
    );
`endif
endinterface

// File: rtl/sha2_schedule_engine.sv
// -----------------------------------------------------------------------------
// sha2_schedule_engine
// SHA-2 message-schedule generator. Loads one 16-word block and streams
// W[0]..W[ROUNDS-1] over a valid/ready handshake. WORD_W=32/ROUNDS=64 covers
// SHA-224/256, WORD_W=64/ROUNDS=80 covers SHA-384/512.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high; clears all state
//   bus    : sha2_schedule_engine_if.slave (start, block_in, busy, w_valid,
//            w_ready, w_out, w_index, done [, abort])
//
// Optional feature: define SHA2_SCHED_ABORT_EN to add bus.abort, which drops
// the running block without a done pulse. Without it a block always runs to
// completion or reset.
//
// A 16-entry sliding window holds W[t..t+15]; w_out is the window head, so the
// emitted word comes straight from a flop and is stable under backpressure.
// -----------------------------------------------------------------------------
module sha2_schedule_engine #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    sha2_schedule_engine_if.slave bus
);

    localparam int IDX_W = $clog2(ROUNDS);

    generate
        if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
            $error("sha2_schedule_engine: WORD_W must be 32 or 64");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                done_r;
    logic                done_nxt_s;
    logic                load_s;
    logic                shift_s;
    logic                last_s;
    logic                abort_s;
    logic [IDX_W-1:0]    t_r;
    logic [WORD_W-1:0]   wbuf_r [16];
    logic [WORD_W-1:0]   w_new_s;

    // Rotate right by n within WORD_W bits.
    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
        rotr = (x >> n) | (x << (WORD_W - n));
    endfunction

    // Small sigma 0 for the selected word width.
    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) begin
            sig0 = rotr(x, 32'd7) ^ rotr(x, 32'd18) ^ (x >> 3);
        end else begin
            sig0 = rotr(x, 32'd1) ^ rotr(x, 32'd8) ^ (x >> 7);
        end
    endfunction

    // Small sigma 1 for the selected word width.
    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) begin
            sig1 = rotr(x, 32'd17) ^ rotr(x, 32'd19) ^ (x >> 10);
        end else begin
            sig1 = rotr(x, 32'd19) ^ rotr(x, 32'd61) ^ (x >> 6);
        end
    endfunction

`ifdef SHA2_SCHED_ABORT_EN
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif

    // Word entering the window tail; the adder wraps mod 2^WORD_W by width.
    // Words past W[ROUNDS-1] are still formed here but never emitted.
    assign w_new_s = sig1(wbuf_r[14]) + wbuf_r[9] + sig0(wbuf_r[1]) + wbuf_r[0];
    assign last_s  = (t_r == IDX_W'(ROUNDS - 1));

    // Next-state and control decode for the load/stream sequencer.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        done_nxt_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    load_s      = 1'b1;
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                // abort wins over a transfer in the same cycle; start is ignored
                if (abort_s) begin
                    state_nxt_s = S_IDLE;
                end else if (bus.w_ready) begin
                    shift_s = 1'b1;
                    if (last_s) begin
                        state_nxt_s = S_IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = S_RUN;
                    end
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Sequencer state and the registered done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Sliding schedule window and round counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) begin
                wbuf_r[k] <= '0;
            end
            t_r <= '0;
        end else if (load_s) begin
            for (int k = 0; k < 16; k++) begin
                wbuf_r[k] <= bus.block_in[16*WORD_W-1-k*WORD_W -: WORD_W];
            end
            t_r <= '0;
        end else if (shift_s) begin
            for (int k = 0; k < 15; k++) begin
                wbuf_r[k] <= wbuf_r[k+1];
            end
            wbuf_r[15] <= w_new_s;
            t_r        <= t_r + IDX_W'(1'b1);
        end else begin
            // no transfer: window and counter hold
        end
    end

    assign bus.busy    = (state_r == S_RUN);
    assign bus.w_valid = (state_r == S_RUN);
    assign bus.w_out   = wbuf_r[0];
    assign bus.w_index = t_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_sha2_schedule_engine.sv
module tb_sha2_schedule_engine;

    typedef logic [63:0] words_t [16];
    typedef struct {
        logic [511:0] blk;
        int           idx;
        logic [31:0]  exp_w;
    } vec_t;

    localparam int NV = 12;

    logic clk;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    sha2_schedule_engine_if #(.WORD_W(32), .IDX_W(6)) b32 ();
    sha2_schedule_engine_if #(.WORD_W(64), .IDX_W(7)) b64 ();

    sha2_schedule_engine #(.WORD_W(32), .ROUNDS(64)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (b32.slave)
    );

    sha2_schedule_engine #(.WORD_W(64), .ROUNDS(80)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (b64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // reference schedule produced by the bench model
    logic [63:0] mw [0:79];
    // captured stream of the 32-bit instance
    logic [31:0] got32 [0:127];
    int          gidx32 [0:127];
    int          cnt, done_cnt, done_cyc, hold_bad;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rot(input logic [63:0] x, input int n, input int w);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < w; i++) y[i] = x[(i + n) % w];
        return y;
    endfunction

    function automatic words_t w32(input logic [511:0] b);
        words_t m;
        for (int k = 0; k < 16; k++) m[k] = {32'h0, b[511-32*k -: 32]};
        return m;
    endfunction

    function automatic words_t w64(input logic [1023:0] b);
        words_t m;
        for (int k = 0; k < 16; k++) m[k] = b[1023-64*k -: 64];
        return m;
    endfunction

    // Textbook schedule recurrence, bit-loop rotations, explicit masking.
    task automatic model(input words_t m, input int w, input int rounds);
        logic [63:0] mask, s0, s1, x;
        mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        for (int t = 0; t < 16; t++) mw[t] = m[t];
        for (int t = 16; t < rounds; t++) begin
            x  = mw[t-15];
            s0 = (w == 32) ? (rot(x, 7, 32) ^ rot(x, 18, 32) ^ (x >> 3))
                           : (rot(x, 1, 64) ^ rot(x, 8, 64) ^ (x >> 7));
            x  = mw[t-2];
            s1 = (w == 32) ? (rot(x, 17, 32) ^ rot(x, 19, 32) ^ (x >> 10))
                           : (rot(x, 19, 64) ^ rot(x, 61, 64) ^ (x >> 6));
            mw[t] = (s1 + mw[t-7] + s0 + mw[t-16]) & mask;
        end
    endtask

    // Call at a negedge with the engine idle; returns at the negedge where W[0] shows.
    task automatic start32(input logic [511:0] blk);
        b32.block_in = blk;
        b32.start    = 1'b1;
        @(negedge clk);
        b32.start    = 1'b0;
    endtask

    task automatic drain32();
        bit ok;
        ok = 1'b0;
        b32.w_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (!b32.w_valid && !b32.done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("drain32 timeout", 64'd1, 64'd0);
    endtask

    // Stream one block, optionally stalling at one index or pulsing start mid-run.
    task automatic run32(input int stall_at, input int stall_len, input int start_at,
                         input logic [511:0] alt, input int ncyc);
        int stall_rem;
        bit stalled, started;
        stall_rem = 0; stalled = 1'b0; started = 1'b0;
        cnt = 0; done_cnt = 0; done_cyc = -1; hold_bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            b32.start = 1'b0;
            if (stall_at >= 0 && !stalled && b32.w_valid && int'(b32.w_index) == stall_at) begin
                stalled   = 1'b1;
                stall_rem = stall_len;
            end
            if (stall_rem > 0) begin
                b32.w_ready = 1'b0;
                stall_rem--;
                if (b32.w_out !== mw[stall_at][31:0] || int'(b32.w_index) != stall_at) hold_bad++;
            end else begin
                b32.w_ready = 1'b1;
            end
            if (start_at >= 0 && !started && b32.w_valid && int'(b32.w_index) == start_at) begin
                b32.start    = 1'b1;
                b32.block_in = alt;
                started      = 1'b1;
            end
            if (b32.w_valid && b32.w_ready && cnt < 128) begin
                got32[cnt]  = b32.w_out;
                gidx32[cnt] = int'(b32.w_index);
                cnt++;
            end
            if (b32.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(negedge clk);
        end
        b32.start   = 1'b0;
        b32.w_ready = 1'b1;
    endtask

    task automatic check_stream32(input string nm, input int exp_done_cyc);
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (i >= cnt || got32[i] !== mw[i][31:0] || gidx32[i] != i) bad++;
        end
        check({nm, " word mismatches"}, bad, 0);
        check({nm, " transfers"}, cnt, 64);
        check({nm, " done pulses"}, done_cnt, 1);
        check({nm, " done cycle"}, done_cyc, exp_done_cyc);
    endtask

    logic [511:0]  blk_abc, blk_one;
    logic [1023:0] blk64_one;
    vec_t          vt [NV];
    words_t        mwords;
    bit            ok;
    int            dn, vld, dcyc, last_idx, bad64, cnt64;
    logic [63:0]   got64 [0:79];

    initial begin
        blk_abc   = {32'h6162_6380, 448'h0, 32'h0000_0018};
        blk_one   = {32'h0000_0001, 480'h0};
        blk64_one = {64'h0000_0000_0000_0001, 960'h0};

        vt[0]  = '{blk_abc, 0,  32'h6162_6380};
        vt[1]  = '{blk_abc, 1,  32'h0000_0000};
        vt[2]  = '{blk_abc, 7,  32'h0000_0000};
        vt[3]  = '{blk_abc, 15, 32'h0000_0018};
        vt[4]  = '{blk_abc, 16, 32'h6162_6380};
        vt[5]  = '{blk_abc, 17, 32'h000F_0000};
        vt[6]  = '{blk_abc, 18, 32'h7DA8_6405};
        vt[7]  = '{blk_abc, 19, 32'h6000_03C6};
        vt[8]  = '{blk_one, 0,  32'h0000_0001};
        vt[9]  = '{blk_one, 16, 32'h0000_0001};
        vt[10] = '{blk_one, 17, 32'h0000_0000};
        vt[11] = '{blk_one, 18, 32'h0000_A000};

        reset = 1'b1;
        b32.start = 1'b0; b32.block_in = '0; b32.w_ready = 1'b0;
        b64.start = 1'b0; b64.block_in = '0; b64.w_ready = 1'b0;
`ifdef SHA2_SCHED_ABORT_EN
        b32.abort = 1'b0; b64.abort = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        check("reset w_valid", b32.w_valid, 0);
        check("reset busy",    b32.busy,    0);
        check("reset done",    b32.done,    0);
        check("reset w_out",   b32.w_out,   0);
        check("reset w_index", b32.w_index, 0);
        check("reset64 w_valid", b64.w_valid, 0);
        reset = 1'b0;
        @(negedge clk);

        // directed vectors: start the block, advance to the index, compare the word
        for (int v = 0; v < NV; v++) begin
            start32(vt[v].blk);
            b32.w_ready = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 70; c++) begin
                if (b32.w_valid && int'(b32.w_index) == vt[v].idx) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (ok) check($sformatf("vec%0d W%0d", v, vt[v].idx), b32.w_out, vt[v].exp_w);
            else    check($sformatf("vec%0d reach", v), 64'd0, 64'd1);
            drain32();
        end

        // full "abc" stream, no backpressure
        mwords = w32(blk_abc);
        model(mwords, 32, 64);
        start32(blk_abc);
        check("abc latency w_valid", b32.w_valid, 1);
        check("abc busy", b32.busy, 1);
        run32(-1, 0, -1, '0, 80);
        check_stream32("abc", 64);
        check("abc idle busy", b32.busy, 0);

        // backpressure at W17 for 5 cycles
        start32(blk_abc);
        run32(17, 5, -1, '0, 80);
        check_stream32("stall", 69);
        check("stall hold violations", hold_bad, 0);

        // start during RUN is ignored
        start32(blk_abc);
        run32(-1, 0, 30, blk_one, 80);
        check_stream32("start ignored", 64);

        // reset mid-run at W40, then replay
        start32(blk_abc);
        b32.w_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (b32.w_valid && b32.w_index == 6'd40) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("rst40 reach", 64'd0, 64'd1);
        reset = 1'b1;
        #1;
        check("rst40 w_valid", b32.w_valid, 0);
        check("rst40 busy",    b32.busy,    0);
        check("rst40 w_out",   b32.w_out,   0);
        check("rst40 w_index", b32.w_index, 0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0; vld = 0;
        for (int c = 0; c < 70; c++) begin
            if (b32.done) dn++;
            if (b32.w_valid) vld++;
            @(negedge clk);
        end
        check("rst40 no done", dn, 0);
        check("rst40 stays idle", vld, 0);
        start32(blk_abc);
        run32(-1, 0, -1, '0, 80);
        check_stream32("replay", 64);

        // back-to-back: start in the done cycle
        start32(blk_abc);
        b32.w_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (b32.done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("b2b done timeout", 64'd0, 64'd1);
        b32.block_in = blk_one;
        b32.start    = 1'b1;
        @(negedge clk);
        b32.start    = 1'b0;
        check("b2b w_valid", b32.w_valid, 1);
        check("b2b w_index", b32.w_index, 0);
        check("b2b W0",      b32.w_out,   32'h0000_0001);
        drain32();

        // 64-bit / 80-round instance
        mwords = w64(blk64_one);
        model(mwords, 64, 80);
        b64.block_in = blk64_one;
        b64.w_ready  = 1'b1;
        b64.start    = 1'b1;
        @(negedge clk);
        b64.start = 1'b0;
        cnt64 = 0; dn = 0; dcyc = -1; last_idx = -1; bad64 = 0;
        for (int c = 0; c < 95; c++) begin
            if (b64.w_valid) begin
                if (cnt64 < 80) begin
                    got64[cnt64] = b64.w_out;
                    if (b64.w_out !== mw[cnt64] || int'(b64.w_index) != cnt64) bad64++;
                end else begin
                    bad64++;
                end
                last_idx = int'(b64.w_index);
                cnt64++;
            end
            if (b64.done) begin
                dn++;
                if (dcyc < 0) dcyc = c;
            end
            @(negedge clk);
        end
        check("w64 word mismatches", bad64, 0);
        check("w64 transfers", cnt64, 80);
        check("w64 last index", last_idx, 79);
        check("w64 done pulses", dn, 1);
        check("w64 done cycle", dcyc, 80);
        check("w64 W0",  got64[0],  64'h0000_0000_0000_0001);
        check("w64 W15", got64[15], 64'h0000_0000_0000_0000);
        check("w64 W16", got64[16], 64'h0000_0000_0000_0001);
        check("w64 W18", got64[18], 64'h0000_2000_0000_0008);

`ifdef SHA2_SCHED_ABORT_EN
        // abort at W10 together with a ready consumer, restart next cycle
        start32(blk_abc);
        b32.w_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (b32.w_valid && b32.w_index == 6'd10) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("abort reach", 64'd0, 64'd1);
        b32.abort = 1'b1;
        @(negedge clk);
        b32.abort = 1'b0;
        check("abort w_valid", b32.w_valid, 0);
        check("abort done",    b32.done,    0);
        check("abort busy",    b32.busy,    0);
        b32.block_in = blk_one;
        b32.start    = 1'b1;
        @(negedge clk);
        b32.start    = 1'b0;
        check("abort restart w_valid", b32.w_valid, 1);
        check("abort restart w_index", b32.w_index, 0);
        check("abort restart W0",      b32.w_out,   32'h0000_0001);
        drain32();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
